// File: rtl/vmm_result_accumulator.sv
// VMM result accumulator: removes ADC offset from NPU tile results,
// sums WL-tile partials per BL and streams one sum per BL per vector.
module vmm_result_accumulator #(
    parameter int AXIS_DATA_WIDTH = 16,
    parameter int ADC_BITS        = 6,
    parameter int ACC_WIDTH       = 32,
    parameter int MAX_NUM_BL      = 256,
    parameter int MAX_TILES       = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cfg_start,
    input  logic [$clog2(MAX_NUM_BL+1)-1:0] cfg_num_bl,
    input  logic [$clog2(MAX_TILES+1)-1:0]  cfg_num_tiles,
    input  logic [3:0]                     cfg_num_vectors,
    input  logic [ADC_BITS-1:0]            cfg_offset,
    output logic                           busy,
    output logic                           done,
    output logic                           err_len,
    input  logic [AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    output logic                           s_axis_tready,
    output logic [ACC_WIDTH-1:0]           m_axis_tdata,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    input  logic                           m_axis_tready
);

    localparam int BL_W = $clog2(MAX_NUM_BL + 1);
    localparam int AW   = $clog2(MAX_NUM_BL);
    localparam int TL_W = $clog2(MAX_TILES + 1);
    localparam int SW   = ADC_BITS + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_EMIT
    } state_t;

    state_t state, state_nxt;

    logic [BL_W-1:0]      num_bl_r;
    logic [TL_W-1:0]      num_tiles_r;
    logic [3:0]           num_vec_r;
    logic [ADC_BITS-1:0]  offset_r;
    logic [BL_W-1:0]      idx;
    logic [TL_W-1:0]      tile;
    logic [3:0]           vec;

    logic [ACC_WIDTH-1:0] acc [MAX_NUM_BL];
    logic [AW-1:0]        addr;
    logic [ACC_WIDTH-1:0] rd_data;
    logic                 mem_we;
    logic [ACC_WIDTH-1:0] mem_wd;

    logic signed [SW-1:0] sample;
    logic [ACC_WIDTH-1:0] sample_ext;

    logic s_fire, m_fire, in_range, clr_last, last_tile;
    logic ld, emit_end, vec_last;

    logic unused_inputs;
    assign unused_inputs = ^{s_axis_tstrb, s_axis_tdata[AXIS_DATA_WIDTH-1:ADC_BITS]};

    assign busy          = (state != S_IDLE);
    assign s_axis_tready = (state == S_ACCUM);

    assign addr    = idx[AW-1:0];
    assign rd_data = acc[addr];

    assign sample = $signed({2'b00, s_axis_tdata[ADC_BITS-1:0]})
                  - $signed({2'b00, offset_r});
    assign sample_ext = {{(ACC_WIDTH-SW){sample[SW-1]}}, sample};

    assign s_fire    = s_axis_tready & s_axis_tvalid;
    assign m_fire    = m_axis_tvalid & m_axis_tready;
    assign in_range  = (idx < num_bl_r);
    assign clr_last  = (idx == num_bl_r - BL_W'(1));
    assign last_tile = (tile == num_tiles_r - TL_W'(1));
    assign vec_last  = ((vec + 4'd1) == num_vec_r);
    assign emit_end  = (state == S_EMIT) & m_fire & m_axis_tlast;
    // Output register refills whenever it is empty or being drained.
    assign ld = (state == S_EMIT) & (~m_axis_tvalid | m_axis_tready) & in_range;

    always_comb begin
        mem_we = 1'b0;
        mem_wd = '0;
        if (state == S_CLEAR) begin
            mem_we = 1'b1;
        end else if (s_fire && in_range) begin
            mem_we = 1'b1;
            mem_wd = rd_data + sample_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) acc[addr] <= mem_wd;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (cfg_start) state_nxt = S_CLEAR;
            S_CLEAR: if (clr_last) state_nxt = S_ACCUM;
            S_ACCUM: if (s_fire && s_axis_tlast && last_tile) state_nxt = S_EMIT;
            S_EMIT:  if (emit_end) state_nxt = vec_last ? S_IDLE : S_CLEAR;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_bl_r      <= '0;
            num_tiles_r   <= '0;
            num_vec_r     <= '0;
            offset_r      <= '0;
            idx           <= '0;
            tile          <= '0;
            vec           <= '0;
            err_len       <= 1'b0;
            done          <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        num_bl_r    <= cfg_num_bl;
                        num_tiles_r <= cfg_num_tiles;
                        num_vec_r   <= cfg_num_vectors;
                        offset_r    <= cfg_offset;
                        err_len     <= 1'b0;
                        idx         <= '0;
                        vec         <= '0;
                    end
                end
                S_CLEAR: begin
                    idx  <= clr_last ? '0 : idx + BL_W'(1);
                    tile <= '0;
                end
                S_ACCUM: begin
                    if (s_fire) begin
                        if (!in_range) err_len <= 1'b1;
                        if (s_axis_tlast) begin
                            if (idx + BL_W'(1) != num_bl_r) err_len <= 1'b1;
                            idx  <= '0;
                            tile <= tile + TL_W'(1);
                        end else if (in_range) begin
                            idx <= idx + BL_W'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (ld) begin
                        m_axis_tdata  <= rd_data;
                        m_axis_tlast  <= clr_last;
                        m_axis_tvalid <= 1'b1;
                        idx           <= idx + BL_W'(1);
                    end else if (m_fire) begin
                        m_axis_tvalid <= 1'b0;
                    end
                    if (emit_end) begin
                        m_axis_tlast <= 1'b0;
                        idx          <= '0;
                        vec          <= vec + 4'd1;
                        done         <= vec_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
